// File: rtl/alu_seq_unit.sv
// Sequential switch ALU: debounced-edge key presses start single-cycle
// operations or a WIDTH-cycle shift-add multiply, with a stepping mode register.
module alu_seq_unit #(
  parameter int WIDTH = 4
) (
  input  logic                 CLOCK_50,
  input  logic                 rst_n,
  input  logic                 mode_key_n,
  input  logic                 go_key_n,
  input  logic [1:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [1:0]           mode,
  output logic [2*WIDTH-1:0]   result,
  output logic                 ovf,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           mode_sync_q, go_sync_q;
  logic                 mode_prev_q, go_prev_q;
  logic                 mode_press_s, go_press_s;
  logic [1:0]           mode_q, mode_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     a_op_q, a_op_d, b_op_q, b_op_d;
  logic [1:0]           op_q, op_d, opmode_q, opmode_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d, mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 ovf_q, ovf_d, busy_q, busy_d, done_q, done_d;
  logic [WIDTH:0]       sum_s, diff_s, acc_sum_s;
  logic [2*WIDTH-1:0]   exec_res_s, mul_step_s;
  logic                 exec_ovf_s;

  // Key synchronisers and previous-value flops; released keys read as 1.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      mode_sync_q <= 2'b11;
      go_sync_q   <= 2'b11;
      mode_prev_q <= 1'b1;
      go_prev_q   <= 1'b1;
    end else begin
      mode_sync_q <= {mode_sync_q[0], mode_key_n};
      go_sync_q   <= {go_sync_q[0], go_key_n};
      mode_prev_q <= mode_sync_q[1];
      go_prev_q   <= go_sync_q[1];
    end
  end

  assign mode_press_s = mode_prev_q & ~mode_sync_q[1];
  assign go_press_s   = go_prev_q & ~go_sync_q[1];

  // Single-cycle datapath evaluated on the latched operands.
  always_comb begin
    sum_s      = {1'b0, a_op_q} + {1'b0, b_op_q};
    diff_s     = {1'b0, a_op_q} - {1'b0, b_op_q};
    acc_sum_s  = {1'b0, acc_q} + {1'b0, a_op_q};
    exec_res_s = '0;
    exec_ovf_s = 1'b0;
    case (opmode_q)
      2'd1: begin
        case (op_q)
          2'b00: begin
            exec_res_s = {{WIDTH{1'b0}}, sum_s[WIDTH-1:0]};
            exec_ovf_s = sum_s[WIDTH];
          end
          2'b01: begin
            exec_res_s = {{WIDTH{1'b0}}, diff_s[WIDTH-1:0]};
            exec_ovf_s = diff_s[WIDTH];
          end
          2'b11: begin
            exec_res_s = {{WIDTH{1'b0}}, acc_sum_s[WIDTH-1:0]};
            exec_ovf_s = acc_sum_s[WIDTH];
          end
          default: begin
            exec_res_s = '0;
            exec_ovf_s = 1'b0;
          end
        endcase
      end
      2'd2: begin
        case (op_q)
          2'b00:   exec_res_s = {{WIDTH{1'b0}}, a_op_q & b_op_q};
          2'b01:   exec_res_s = {{WIDTH{1'b0}}, a_op_q | b_op_q};
          2'b10:   exec_res_s = {{WIDTH{1'b0}}, a_op_q ^ b_op_q};
          default: exec_res_s = {{WIDTH{1'b0}}, ~a_op_q};
        endcase
      end
      2'd3: begin
        case (op_q)
          2'b00:   exec_res_s = {{(2*WIDTH-1){1'b0}}, (a_op_q == b_op_q)};
          2'b01:   exec_res_s = {{(2*WIDTH-1){1'b0}}, (a_op_q < b_op_q)};
          2'b10:   exec_res_s = {{(2*WIDTH-1){1'b0}}, (a_op_q > b_op_q)};
          default: exec_res_s = {{WIDTH{1'b0}}, (a_op_q > b_op_q) ? a_op_q : b_op_q};
        endcase
      end
      default: begin
        exec_res_s = '0;
        exec_ovf_s = 1'b0;
      end
    endcase
  end

  assign mul_step_s = mplier_q[0] ? mcand_q : '0;

  // Next-state, operand capture, multiply stepping and output updates.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    acc_d    = acc_q;
    a_op_d   = a_op_q;
    b_op_d   = b_op_q;
    op_d     = op_q;
    opmode_d = opmode_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (go_press_s) begin
          a_op_d   = a;
          b_op_d   = b;
          op_d     = op;
          opmode_d = mode_q;
          prod_d   = '0;
          mcand_d  = {{WIDTH{1'b0}}, a};
          mplier_d = b;
          cnt_d    = '0;
          if (mode_q == 2'd1 && op == 2'b10) begin
            state_d = S_MUL;
          end else begin
            state_d = S_EXEC;
          end
        end else if (mode_press_s) begin
          // Wrapping back to idle mode also clears the running sum.
          mode_d = mode_q + 2'd1;
          if (mode_q == 2'd3) begin
            acc_d = '0;
          end else begin
            acc_d = acc_q;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        result_d = exec_res_s;
        ovf_d    = exec_ovf_s;
        if (opmode_q == 2'd1 && op_q == 2'b11) begin
          acc_d = acc_sum_s[WIDTH-1:0];
        end else begin
          acc_d = acc_q;
        end
        state_d = S_DONE;
      end
      S_MUL: begin
        prod_d   = prod_q + mul_step_s;
        mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) begin
          result_d = prod_q + mul_step_s;
          ovf_d    = 1'b0;
          state_d  = S_DONE;
        end else begin
          state_d  = S_MUL;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_EXEC) || (state_d == S_MUL);
    done_d = (state_d == S_DONE);
  end

  // Architectural state and registered outputs.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mode_q   <= 2'd0;
      acc_q    <= '0;
      a_op_q   <= '0;
      b_op_q   <= '0;
      op_q     <= 2'b00;
      opmode_q <= 2'd0;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      acc_q    <= acc_d;
      a_op_q   <= a_op_d;
      b_op_q   <= b_op_d;
      op_q     <= op_d;
      opmode_q <= opmode_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign mode   = mode_q;
  assign result = result_q;
  assign ovf    = ovf_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Bench for alu_seq_unit: key-press tasks drive a cycle-accurate expectation
// set from an arithmetic model; one loop compares every output each cycle.
module tb_alu_seq_unit;

  localparam int W = 4;
  localparam int M = 1 << W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             mode_key_n = 1'b1;
  logic             go_key_n = 1'b1;
  logic [1:0]       op = 2'b00;
  logic [W-1:0]     a = '0;
  logic [W-1:0]     b = '0;
  logic [1:0]       mode;
  logic [2*W-1:0]   result;
  logic             ovf, busy, done;

  int               n_tests = 0;
  int               n_fail = 0;
  bit               chk_en = 1'b0;
  logic [1:0]       exp_mode;
  logic [2*W-1:0]   exp_result;
  logic             exp_ovf, exp_busy, exp_done;
  int               m_mode = 0;
  int               m_acc = 0;

  alu_seq_unit #(.WIDTH(W)) dut (
    .CLOCK_50   (clk),
    .rst_n      (rst_n),
    .mode_key_n (mode_key_n),
    .go_key_n   (go_key_n),
    .op         (op),
    .a          (a),
    .b          (b),
    .mode       (mode),
    .result     (result),
    .ovf        (ovf),
    .busy       (busy),
    .done       (done)
  );

  always #10 clk = ~clk;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Outcome of one operation from the operation tables, using plain integers.
  function automatic void model(input int md, input int opc, input int av, input int bv,
                                inout int acc, output int res, output int ov);
    res = 0;
    ov  = 0;
    if (md == 1) begin
      case (opc)
        0: begin res = (av + bv) % M; ov = (av + bv >= M) ? 1 : 0; end
        1: begin res = (av - bv + M) % M; ov = (av < bv) ? 1 : 0; end
        2: res = av * bv;
        default: begin ov = (acc + av >= M) ? 1 : 0; acc = (acc + av) % M; res = acc; end
      endcase
    end else if (md == 2) begin
      case (opc)
        0: res = av & bv;
        1: res = av | bv;
        2: res = av ^ bv;
        default: res = M - 1 - av;
      endcase
    end else if (md == 3) begin
      case (opc)
        0: res = (av == bv) ? 1 : 0;
        1: res = (av < bv) ? 1 : 0;
        2: res = (av > bv) ? 1 : 0;
        default: res = (av > bv) ? av : bv;
      endcase
    end
  endfunction

  task automatic set_reset_exp();
    m_mode = 0;
    m_acc = 0;
    exp_mode = 2'd0;
    exp_result = '0;
    exp_ovf = 1'b0;
    exp_busy = 1'b0;
    exp_done = 1'b0;
  endtask

  task automatic check_reset_lit(input string tag);
    cmp({tag, "_mode"}, {30'd0, mode}, 32'd0);
    cmp({tag, "_result"}, {24'd0, result}, 32'd0);
    cmp({tag, "_ovf"}, {31'd0, ovf}, 32'd0);
    cmp({tag, "_busy"}, {31'd0, busy}, 32'd0);
    cmp({tag, "_done"}, {31'd0, done}, 32'd0);
  endtask

  task automatic press_mode();
    @(negedge clk); mode_key_n = 1'b0;
    @(posedge clk);                       // edge k
    @(negedge clk); mode_key_n = 1'b1;
    @(posedge clk);                       // k+1
    @(posedge clk); #1;                   // k+2: mode steps
    m_mode = (m_mode + 1) % 4;
    if (m_mode == 0) m_acc = 0;
    exp_mode = 2'(m_mode);
    repeat (2) @(posedge clk);
  endtask

  // One go press; inject adds a go+mode press mid-multiply, with_mode presses mode alongside go.
  task automatic go(input int av, input int bv, input int opc, input bit inject, input bit with_mode);
    int r, v, nb;
    @(negedge clk);
    a = W'(av); b = W'(bv); op = 2'(opc);
    go_key_n = 1'b0;
    if (with_mode) mode_key_n = 1'b0;
    @(posedge clk);                       // edge k
    @(negedge clk); go_key_n = 1'b1; mode_key_n = 1'b1;
    @(posedge clk);                       // k+1
    @(posedge clk); #1;                   // k+2: busy
    nb = (m_mode == 1 && opc == 2) ? W : 1;
    model(m_mode, opc, av, bv, m_acc, r, v);
    exp_busy = 1'b1;
    for (int i = 0; i < nb; i++) begin
      @(negedge clk);
      if (inject && i == 0) begin go_key_n = 1'b0; mode_key_n = 1'b0; end
      if (inject && i == 1) begin go_key_n = 1'b1; mode_key_n = 1'b1; end
      @(posedge clk); #1;
    end
    exp_busy = 1'b0;
    exp_done = 1'b1;
    exp_result = (2*W)'(r);
    exp_ovf = v[0];
    @(posedge clk); #1;
    exp_done = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic go_then_reset(input int av, input int bv);
    @(negedge clk);
    a = W'(av); b = W'(bv); op = 2'b10;
    go_key_n = 1'b0;
    @(posedge clk);
    @(negedge clk); go_key_n = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    exp_busy = 1'b1;
    @(posedge clk); #4;
    rst_n = 1'b0;
    set_reset_exp();
    #1;
    check_reset_lit("mulrst");
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (W + 4) @(posedge clk);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (chk_en) begin
          cmp("cyc_mode", {30'd0, mode}, {30'd0, exp_mode});
          cmp("cyc_result", {24'd0, result}, {24'd0, exp_result});
          cmp("cyc_ovf", {31'd0, ovf}, {31'd0, exp_ovf});
          cmp("cyc_busy", {31'd0, busy}, {31'd0, exp_busy});
          cmp("cyc_done", {31'd0, done}, {31'd0, exp_done});
          if (busy && done) cmp("busy_and_done", 32'd1, 32'd0);
        end
      end
    join_none

    #2 rst_n = 1'b0;
    set_reset_exp();
    #1 check_reset_lit("rst0");
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    press_mode();
    cmp("mode_after_press", {30'd0, mode}, 32'd1);
    go(9, 8, 0, 1'b0, 1'b0);
    cmp("add_res", {24'd0, result}, 32'h01);
    cmp("add_ovf", {31'd0, ovf}, 32'd1);
    go(3, 5, 1, 1'b0, 1'b0);
    cmp("sub_res", {24'd0, result}, 32'h0E);
    cmp("sub_ovf", {31'd0, ovf}, 32'd1);
    go(15, 13, 2, 1'b1, 1'b0);
    cmp("mul_res", {24'd0, result}, 32'hC3);
    cmp("mul_ovf", {31'd0, ovf}, 32'd0);
    cmp("mul_mode", {30'd0, mode}, 32'd1);

    go(7, 0, 3, 1'b0, 1'b0);
    cmp("acc1", {24'd0, result}, 32'h07);
    go(7, 0, 3, 1'b0, 1'b0);
    cmp("acc2", {24'd0, result}, 32'h0E);
    go(7, 0, 3, 1'b0, 1'b0);
    cmp("acc3", {24'd0, result}, 32'h05);
    cmp("acc3_ovf", {31'd0, ovf}, 32'd1);

    press_mode();
    go(12, 10, 0, 1'b0, 1'b0);
    cmp("and_res", {24'd0, result}, 32'h08);
    go(12, 10, 2, 1'b0, 1'b0);
    cmp("xor_res", {24'd0, result}, 32'h06);
    go(12, 10, 3, 1'b0, 1'b0);
    cmp("not_res", {24'd0, result}, 32'h03);

    press_mode();
    go(5, 12, 3, 1'b0, 1'b0);
    cmp("max_res", {24'd0, result}, 32'h0C);
    go(5, 12, 1, 1'b0, 1'b0);
    cmp("lt_res", {24'd0, result}, 32'h01);
    go(5, 12, 0, 1'b0, 1'b0);
    cmp("eq_res", {24'd0, result}, 32'h00);
    go(5, 12, 2, 1'b0, 1'b0);
    cmp("gt_res", {24'd0, result}, 32'h00);

    press_mode();
    cmp("mode_wrap", {30'd0, mode}, 32'd0);
    go(9, 9, 0, 1'b0, 1'b0);
    cmp("mode0_res", {24'd0, result}, 32'h00);
    press_mode();
    go(7, 0, 3, 1'b0, 1'b0);
    cmp("acc_cleared", {24'd0, result}, 32'h07);
    cmp("acc_cleared_ovf", {31'd0, ovf}, 32'd0);

    go(2, 3, 0, 1'b0, 1'b1);
    cmp("go_wins_res", {24'd0, result}, 32'h05);
    cmp("go_wins_mode", {30'd0, mode}, 32'd1);

    @(negedge clk); #3;
    rst_n = 1'b0;
    set_reset_exp();
    #1 check_reset_lit("rst_mid");
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(posedge clk);

    press_mode();
    go_then_reset(15, 13);
    cmp("post_rst_mode", {30'd0, mode}, 32'd0);
    cmp("post_rst_done", {31'd0, done}, 32'd0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
